// File: rtl/face_detect_mul_pkg.sv
// Shared widths, tag type and round-robin helper for the face_detect shared multiplier.
package face_detect_mul_pkg;

   localparam int A_W      = 16;
   localparam int B_W      = 7;
   localparam int P_W      = 23;
   localparam int MAX_REQ  = 8;
   localparam int TAG_ID_W = 3;

   typedef struct packed {
      logic                valid;
      logic [TAG_ID_W-1:0] id;
   } tag_t;

   // Returns the first lane at or after ptr (mod nreq) whose valid bit is set.
   // When no lane is valid the result is ptr itself; callers qualify with valid_vec.
   function automatic logic [TAG_ID_W-1:0] next_rr(
      input logic [TAG_ID_W-1:0] ptr,
      input logic [MAX_REQ-1:0]  valid_vec,
      input int                  nreq
   );
      int idx;
      // NOTE: blocking assignments here: a function body is plain sequential code,
      // each line sees the previous line's result within the same evaluation.
      next_rr = ptr;
      for (int k = MAX_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= nreq) idx = idx - nreq;
         if (k < nreq && valid_vec[idx]) next_rr = TAG_ID_W'(idx);
      end
   endfunction

endpackage

// File: rtl/face_detect_mul_pipe.sv
// LAT-stage 16-bit-unsigned x 7-bit-signed multiplier; every stage advances only on ce.
module face_detect_mul_pipe
   import face_detect_mul_pkg::*;
#(
   parameter int LAT = 3
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           ce,
   input  logic [A_W-1:0] a,
   input  logic [B_W-1:0] b,
   output logic [P_W-1:0] p
);

   logic signed [P_W-1:0] a_ext;
   logic signed [P_W-1:0] b_ext;
   logic signed [P_W-1:0] p_stage [LAT];

   assign a_ext = P_W'($signed({1'b0, a}));
   assign b_ext = P_W'($signed(b));

   // NOTE: the product stages are cleared on reset as well, so nothing computed
   // before reset can ever be loaded into the result register afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < LAT; k++) p_stage[k] <= '0;
      end else if (ce) begin
         p_stage[0] <= a_ext * b_ext;
         for (int k = 1; k < LAT; k++) p_stage[k] <= p_stage[k-1];
      end
   end

   assign p = p_stage[LAT-1];

endmodule

// File: rtl/face_detect_mul_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NREQ lanes, with a
// tag pipe, a tagged result register and a global stall when the consumer backpressures.
module face_detect_mul_arbiter
   import face_detect_mul_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int MUL_LAT = 3,
   parameter int ID_W    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*A_W-1:0] req_a,
   input  logic [NREQ*B_W-1:0] req_b,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [ID_W-1:0]     res_id,
   output logic [P_W-1:0]      res_p
);

   logic                ce;
   logic                gnt;
   logic [ID_W-1:0]     ptr;
   logic [ID_W-1:0]     gnt_id;
   logic [TAG_ID_W-1:0] rr_idx;
   logic [A_W-1:0]      a_sel;
   logic [B_W-1:0]      b_sel;
   logic [P_W-1:0]      pipe_p;
   tag_t                tag_q [MUL_LAT];

   assign ce     = !(res_valid && !res_ready);
   assign rr_idx = next_rr(TAG_ID_W'(ptr), MAX_REQ'(req_valid), NREQ);
   assign gnt_id = ID_W'(rr_idx);
   assign gnt    = ce && !reset && req_valid[gnt_id];
   assign a_sel  = req_a[gnt_id*A_W +: A_W];
   assign b_sel  = req_b[gnt_id*B_W +: B_W];

   // NOTE: req_ready gets its all-zero default first so every path assigns it
   // and no latch is inferred.
   always_comb begin
      req_ready = '0;
      if (gnt) req_ready[gnt_id] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr <= '0;
      end else if (gnt) begin
         ptr <= (gnt_id == ID_W'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
      end
   end

   // Tag pipe mirrors the multiplier stages one-for-one so the tail tag matches pipe_p.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < MUL_LAT; k++) tag_q[k] <= '0;
      end else if (ce) begin
         tag_q[0] <= '{valid: gnt, id: TAG_ID_W'(gnt_id)};
         for (int k = 1; k < MUL_LAT; k++) tag_q[k] <= tag_q[k-1];
      end
   end

   face_detect_mul_pipe #(.LAT(MUL_LAT)) u_pipe (
      .clk   (clk),
      .reset (reset),
      .ce    (ce),
      .a     (a_sel),
      .b     (b_sel),
      .p     (pipe_p)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         res_valid <= 1'b0;
         res_id    <= '0;
         res_p     <= '0;
      end else if (ce) begin
         res_valid <= tag_q[MUL_LAT-1].valid;
         res_id    <= ID_W'(tag_q[MUL_LAT-1].id);
         res_p     <= pipe_p;
      end
   end

endmodule

// File: tb/tb_face_detect_mul_arbiter.sv
// Directed and randomized bench for face_detect_mul_arbiter against a slot-queue reference model.
module tb_face_detect_mul_arbiter;

   localparam int NREQ    = 4;
   localparam int MUL_LAT = 3;
   localparam int ID_W    = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic [NREQ-1:0]    vld;
   logic [NREQ-1:0]    req_ready;
   logic [NREQ*16-1:0] req_a;
   logic [NREQ*7-1:0]  req_b;
   logic               res_valid;
   logic               res_ready;
   logic [ID_W-1:0]    res_id;
   logic [22:0]        res_p;

   logic [15:0] a_l [NREQ];
   logic [6:0]  b_l [NREQ];

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*16 +: 16] = a_l[i];
         req_b[i*7 +: 7]   = b_l[i];
      end
   end

   face_detect_mul_arbiter #(.NREQ(NREQ), .MUL_LAT(MUL_LAT), .ID_W(ID_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (vld),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_id    (res_id),
      .res_p     (res_p)
   );

   // Reference model: MUL_LAT in-flight slots plus the visible result.
   typedef struct {
      bit v;
      int id;
      int p;
   } res_t;

   res_t            flight [$];
   res_t            m_out;
   int              m_ptr;
   int              last_gnt;
   logic [NREQ-1:0] obs_rdy;
   int              n_pass  = 0;
   int              n_total = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic model_reset();
      flight.delete();
      for (int k = 0; k < MUL_LAT; k++) flight.push_back('{0, 0, 0});
      m_out = '{0, 0, 0};
      m_ptr = 0;
   endtask

   task automatic check_out();
      logic [22:0] exp_p;
      check("res_valid", 32'(res_valid), 32'(m_out.v));
      if (m_out.v) begin
         exp_p = 23'(m_out.p);
         check("res_id", 32'(res_id), 32'(m_out.id));
         check("res_p", 32'(res_p), 32'(exp_p));
      end
   endtask

   // One clock: check grant at negedge, advance the model at posedge, check outputs at +1.
   task automatic cycle();
      logic [NREQ-1:0] exp_rdy;
      bit              exp_ce;
      int              g;
      res_t            s;
      @(negedge clk);
      exp_rdy = '0;
      g       = -1;
      exp_ce  = !(m_out.v && !res_ready);
      if (!reset && exp_ce) begin
         for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (g < 0 && vld[j]) g = j;
         end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      obs_rdy = req_ready;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      last_gnt = g;
      if (!reset && exp_ce) begin
         s     = flight.pop_back();
         m_out = s;
         if (g >= 0) begin
            flight.push_front('{1, g, int'(a_l[g]) * int'($signed(b_l[g]))});
            m_ptr = (g + 1) % NREQ;
         end else begin
            flight.push_front('{0, 0, 0});
         end
      end
      #1;
      check_out();
   endtask

   task automatic new_ops(input int lane);
      a_l[lane] = 16'($urandom);
      b_l[lane] = 7'($urandom);
   endtask

   task automatic refresh_granted();
      if (last_gnt >= 0) new_ops(last_gnt);
   endtask

   initial begin
      bit served;
      reset     = 1'b1;
      vld       = '0;
      res_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         a_l[i] = '0;
         b_l[i] = '0;
      end
      model_reset();

      // Reset state
      cycle();
      cycle();
      check("rst_res_valid", 32'(res_valid), 32'd0);
      check("rst_res_id", 32'(res_id), 32'd0);
      check("rst_res_p", 32'(res_p), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      reset = 1'b0;
      cycle();
      cycle();

      // Single request on lane 2: result exactly MUL_LAT edges after the handshake
      a_l[2] = 16'd1000;
      b_l[2] = 7'h7D;
      vld    = 4'b0100;
      cycle();
      check("single_ready", 32'(obs_rdy), 32'h4);
      vld = '0;
      for (int k = 0; k < MUL_LAT; k++) cycle();
      check("single_valid", 32'(res_valid), 32'd1);
      check("single_id", 32'(res_id), 32'd2);
      check("single_p", 32'(res_p), 32'h7FF448);
      cycle();

      // All lanes valid: one grant per cycle in rotating order
      for (int i = 0; i < NREQ; i++) new_ops(i);
      vld = '1;
      for (int k = 0; k < 16; k++) begin
         cycle();
         refresh_granted();
      end
      vld = '0;
      for (int k = 0; k < MUL_LAT + 1; k++) cycle();

      // Arithmetic extremes, one lane at a time
      a_l[0] = 16'hFFFF; b_l[0] = 7'h40;
      a_l[1] = 16'hFFFF; b_l[1] = 7'h3F;
      a_l[3] = 16'h0000; b_l[3] = 7'h7F;
      vld = 4'b0001; cycle();
      vld = 4'b0010; cycle();
      vld = 4'b1000; cycle();
      vld = '0;      cycle();
      check("ext_min_id", 32'(res_id), 32'd0);
      check("ext_min_p", 32'(res_p), 32'h400040);
      cycle();
      check("ext_max_id", 32'(res_id), 32'd1);
      check("ext_max_p", 32'(res_p), 32'h3EFFC1);
      cycle();
      check("ext_zero_id", 32'(res_id), 32'd3);
      check("ext_zero_p", 32'(res_p), 32'd0);
      cycle();

      // Backpressure with a full pipe
      for (int i = 0; i < NREQ; i++) new_ops(i);
      vld = '1;
      for (int k = 0; k < 6; k++) begin
         cycle();
         refresh_granted();
      end
      res_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("stall_ready", 32'(obs_rdy), 32'd0);
      end
      res_ready = 1'b1;
      vld       = '0;
      for (int k = 0; k < MUL_LAT + 3; k++) cycle();

      // Reset one cycle after two grants
      vld = 4'b0011;
      cycle();
      refresh_granted();
      cycle();
      vld = '0;
      cycle();
      vld = '1;
      #2 reset = 1'b1;
      #1;
      check("mid_rst_valid", 32'(res_valid), 32'd0);
      check("mid_rst_id", 32'(res_id), 32'd0);
      check("mid_rst_p", 32'(res_p), 32'd0);
      check("mid_rst_ready", 32'(req_ready), 32'd0);
      model_reset();
      cycle();
      cycle();
      reset = 1'b0;
      vld   = '0;
      for (int k = 0; k < MUL_LAT + 2; k++) cycle();
      vld = '1;
      #3;
      check("post_rst_lane0", 32'(req_ready), 32'h1);
      cycle();
      vld = '0;
      for (int k = 0; k < MUL_LAT + 1; k++) cycle();

      // Fairness: lanes 1 and 3 alternate, lane 0 joins later
      vld = 4'b1010;
      for (int k = 0; k < 6; k++) begin
         cycle();
         refresh_granted();
      end
      vld[0] = 1'b1;
      served = 1'b0;
      for (int k = 0; k < NREQ && !served; k++) begin
         cycle();
         if (obs_rdy[0]) begin
            served = 1'b1;
            vld[0] = 1'b0;
         end
         refresh_granted();
      end
      check("lane0_served", 32'(served), 32'd1);
      vld = '0;
      for (int k = 0; k < MUL_LAT + 1; k++) cycle();

      // Randomized traffic with random backpressure
      for (int k = 0; k < 400; k++) begin
         res_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < NREQ; i++) begin
            if (!vld[i] || last_gnt == i) begin
               new_ops(i);
               vld[i] = 1'($urandom_range(0, 1));
            end
         end
         cycle();
      end
      res_ready = 1'b1;
      vld       = '0;
      for (int k = 0; k < MUL_LAT + 4; k++) cycle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
